// File: rtl/inc_seq_gen.sv
// Handshaked ascending index-sequence generator (start..limit inclusive) built on a prefix-AND incrementer.
// Optional INC_SEQ_GEN_WRAP_EN: drops the empty-range check so the counter may wrap through zero.
module inc_seq_gen #(
    parameter int unsigned width = 8,
    parameter int unsigned speed = 1   // 0: ripple prefix-AND, otherwise log-depth prefix-AND
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [width-1:0] start_val_i,
    input  logic [width-1:0] limit_i,
    output logic             idle_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [width-1:0] data_o,
    output logic             last_o,
    output logic             done_o,
    output logic             err_o
);

`ifdef INC_SEQ_GEN_WRAP_EN
    localparam bit RangeCheck = 1'b0;
`else
    localparam bit RangeCheck = 1'b1;
`endif

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

    state_e           state_q;
    logic [width-1:0] cnt_q;
    logic [width-1:0] lim_q;
    logic             last_q;
    logic             done_q;
    logic             err_q;

    logic [width-2:0] po;
    logic [width-1:0] cnt_inc;

    // po[i] = &cnt_q[i:0]; the top bit's prefix would only feed the discarded carry.
    if (speed == 0) begin : g_ripple
        always_comb begin
            logic [width-2:0] t;
            t = cnt_q[width-2:0];
            for (int i = 1; i < width - 1; i++) begin
                t[i] = t[i-1] & cnt_q[i];
            end
            po = t;
        end
    end else begin : g_fast
        always_comb begin
            logic [width-2:0] t;
            t = cnt_q[width-2:0];
            for (int l = 1; l < width - 1; l = l * 2) begin
                for (int i = width - 2; i >= l; i--) begin
                    t[i] = t[i] & t[i-l];
                end
            end
            po = t;
        end
    end

    assign cnt_inc = cnt_q ^ {po, 1'b1};

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            lim_q   <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        if (RangeCheck && (start_val_i > limit_i)) begin
                            err_q <= 1'b1;
                        end else begin
                            state_q <= RUN;
                            cnt_q   <= start_val_i;
                            lim_q   <= limit_i;
                            last_q  <= (start_val_i == limit_i);
                        end
                    end
                end
                RUN: begin
                    if (ready_i) begin
                        if (last_q) begin
                            // Clearing cnt keeps data_o at zero while idle.
                            state_q <= IDLE;
                            cnt_q   <= '0;
                            last_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            cnt_q  <= cnt_inc;
                            last_q <= (cnt_inc == lim_q);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign idle_o  = (state_q == IDLE);
    assign valid_o = (state_q == RUN);
    assign data_o  = cnt_q;
    assign last_o  = last_q;
    assign done_o  = done_q;
    assign err_o   = err_q;

endmodule

// File: tb/tb_inc_seq_gen.sv
// Bench for inc_seq_gen: a queue-of-expected-beats model checked every cycle, plus directed literal pins.
module tb_inc_seq_gen;

`ifdef INC_SEQ_GEN_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] sval = '0;
    logic [7:0] lval = '0;
    logic       rdy = 1'b0;
    logic       idle_o, valid_o, last_o, done_o, err_o;
    logic [7:0] data_o;

    int total = 0;
    int bad = 0;
    int n_done = 0;

    logic [7:0] q[$];     // beats still owed by the generator
    logic       m_done = 1'b0;
    logic       m_err = 1'b0;
    logic [7:0] hs[$];    // beats the DUT actually handed over

    always #5 clk = ~clk;

    inc_seq_gen #(.width(8)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .start_val_i(sval), .limit_i(lval),
        .idle_o(idle_o), .valid_o(valid_o), .ready_i(rdy), .data_o(data_o),
        .last_o(last_o), .done_o(done_o), .err_o(err_o)
    );

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Called at a falling edge: compare, drive inputs, advance the model, step one cycle.
    task automatic cyc(input logic r, input logic s, input logic [7:0] sv, input logic [7:0] lv,
                       input logic rd);
        int n;
        chk("idle", idle_o, q.size() == 0);
        chk("valid", valid_o, q.size() != 0);
        chk("data", data_o, (q.size() != 0) ? q[0] : 8'h00);
        if (q.size() != 0) chk("last", last_o, q.size() == 1);
        chk("done", done_o, m_done);
        chk("err", err_o, m_err);
        if (done_o) n_done++;

        rst_n = r; start = s; sval = sv; lval = lv; rdy = rd;

        if (!r) begin
            q.delete();
            m_done = 1'b0;
            m_err = 1'b0;
        end else begin
            m_done = 1'b0;
            m_err = 1'b0;
            if (q.size() != 0) begin
                if (rd) begin
                    hs.push_back(data_o);
                    void'(q.pop_front());
                    if (q.size() == 0) m_done = 1'b1;
                end
            end else if (s) begin
                if (!WRAP && sv > lv) begin
                    m_err = 1'b1;
                end else begin
                    n = ((int'(lv) - int'(sv)) & 255) + 1;
                    for (int k = 0; k < n; k++) q.push_back(8'((int'(sv) + k) & 255));
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] exp8[$];
        logic [7:0] a, b;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_idle", idle_o, 1);
        chk("rst_valid", valid_o, 0);
        chk("rst_data", data_o, 0);
        chk("rst_last", last_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_err", err_o, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);

        // Reset mid-run: 3..10, two beats, then reset.
        n_done = 0;
        cyc(1, 1, 8'd3, 8'd10, 1);
        cyc(1, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        chk("midrst_idle", idle_o, 1);
        chk("midrst_valid", valid_o, 0);
        chk("midrst_data", data_o, 0);
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 1);
        chk("midrst_no_done", n_done, 0);

        // 5..9 at full throughput.
        hs.delete();
        cyc(1, 1, 8'd5, 8'd9, 1);
        chk("run_first_valid", valid_o, 1);
        for (int i = 0; i < 6; i++) cyc(1, 0, 0, 0, 1);
        exp8 = '{8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
        chk("run_nbeats", hs.size(), 5);
        for (int i = 0; i < 5 && i < hs.size(); i++) chk("run_beat", hs[i], exp8[i]);

        // 0x0F..0x12 with ready pattern 1,0,0,1.
        hs.delete();
        cyc(1, 1, 8'h0F, 8'h12, 0);
        for (int i = 0; i < 16; i++) cyc(1, 0, 0, 0, (i % 4 == 0) || (i % 4 == 3));
        exp8 = '{8'h0F, 8'h10, 8'h11, 8'h12};
        chk("stall_nbeats", hs.size(), 4);
        for (int i = 0; i < 4 && i < hs.size(); i++) chk("stall_beat", hs[i], exp8[i]);

        // Single beat 0xFF, restart in the done cycle.
        cyc(1, 1, 8'hFF, 8'hFF, 0);
        chk("one_data", data_o, 8'hFF);
        chk("one_last", last_o, 1);
        cyc(1, 0, 0, 0, 1);
        chk("one_done", done_o, 1);
        chk("one_idle", idle_o, 1);
        cyc(1, 1, 8'd1, 8'd2, 0);
        chk("restart_valid", valid_o, 1);
        chk("restart_data", data_o, 1);
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 1);

        // Descending range 0xFE..0x01.
        hs.delete();
        cyc(1, 1, 8'hFE, 8'h01, 1);
        if (WRAP) begin
            chk("wrap_err", err_o, 0);
            for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 1);
            exp8 = '{8'hFE, 8'hFF, 8'h00, 8'h01};
            chk("wrap_nbeats", hs.size(), 4);
            for (int i = 0; i < 4 && i < hs.size(); i++) chk("wrap_beat", hs[i], exp8[i]);
        end else begin
            chk("empty_err", err_o, 1);
            chk("empty_idle", idle_o, 1);
            chk("empty_valid", valid_o, 0);
            cyc(1, 0, 0, 0, 1);
            chk("empty_err_gone", err_o, 0);
            chk("empty_nbeats", hs.size(), 0);
        end

        // Randomised traffic.
        for (int i = 0; i < 4000; i++) begin
            a = 8'($urandom);
            b = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'(a + 8'($urandom_range(0, 6)));
            cyc($urandom_range(0, 299) != 0, $urandom_range(0, 2) == 0, a, b,
                $urandom_range(0, 3) != 0);
        end
        cyc(1, 0, 0, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
